prbs31_lock_ctrl: RTL and testbench
===================================

Name: prbs31_lock_ctrl

Overview:
Receive-side sequencer for the team's PRBS31 test path (polynomial x^31+x^28+1). It self-seeds a local PRBS31 generator from the incoming serial stream, verifies alignment, and declares lock. While locked it counts bit errors and drops lock when errors exceed a windowed threshold. It sits after the pin sampling registers and drives the status outputs.

Parameters:
LOCK_CNT, 64, consecutive matching bits in VERIFY required to declare lock (1..65535)
ERR_THRESH, 8, errors within one window that force loss of lock (1..WIN_LEN)
WIN_LEN, 1024, window length in valid bits while LOCKED
CNT_W, 16, width of err_cnt and bit_cnt

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high (despite the name)
en  input  1  enable; 0 forces IDLE
rx_valid  input  1  qualifies rx_bit this cycle
rx_bit  input  1  received serial bit
clr  input  1  synchronous clear of err_cnt/bit_cnt
state  output  2  IDLE=0, LOAD=1, VERIFY=2, LOCKED=3
locked  output  1  high when state==LOCKED
err_pulse  output  1  one-cycle pulse per detected error while LOCKED
lock_lost  output  1  one-cycle pulse on LOCKED->LOAD
err_cnt  output  CNT_W  saturating error count
bit_cnt  output  CNT_W  saturating count of valid bits checked while LOCKED

Behaviour:
- Reset: state=IDLE, lfsr=0, fill/match/window counters=0, all outputs 0.
- All outputs are registered. Effects of a valid bit appear on the edge that samples it.
- Prediction: pred = lfsr[30]^lfsr[27]. Shift form: lfsr <= {lfsr[29:0], x}.
- IDLE: if en=1, go to LOAD next cycle (fill=0).
- LOAD: each valid bit shifts x=rx_bit and increments fill. On the 31st bit, evaluate the new lfsr value. If it is all-zero, stay in LOAD with fill=0. Otherwise go to VERIFY with match=0.
- VERIFY: each valid bit compares rx_bit with pred.
  - Match: shift x=pred, match++. When match reaches LOCK_CNT, go to LOCKED and clear the window counters.
  - Mismatch: discard the bit and go to LOAD with fill=0.
- LOCKED: each valid bit shifts x=pred (free-run), increments bit_cnt (saturating) and increments the window count.
  - Mismatch: err_cnt++ (saturating at 2^CNT_W-1), win_err++, err_pulse=1 for one cycle.
  - If win_err reaches ERR_THRESH: go to LOAD, fill=0, lock_lost=1 for one cycle.
  - At the WIN_LEN-th bit of a window, win_err and the window count reset to 0.
  - Threshold reached on the last bit of a window: the threshold wins and lock is lost.
- rx_valid=0: nothing advances. State and counters hold.
- en=0 in any state: IDLE on the next edge. locked=0. err_cnt/bit_cnt hold. Internal fill/match/window counters clear.
- clr=1: err_cnt=bit_cnt=0 on the next edge. clr wins over a same-cycle increment. State is unaffected.
- Counters never wrap.
- Asynchronous reset mid-operation returns everything to reset values immediately.
- Lock latency from a clean aligned stream: 31+LOCK_CNT valid bits.

Optional Feature:
PRBS_INV_POL_EN:
- Defined: adds input port inv_pol (1 bit). When inv_pol=1, rx_bit is inverted before all LOAD/VERIFY/LOCKED processing. Handles a swapped differential pair.
- Undefined: the port is absent and rx_bit is used unmodified.

Test Plan:
1. Reset, en=1, clean PRBS31 stream (generator seeded all-ones), rx_valid=1 every cycle -> locked=1 on the edge sampling valid bit 95 (31+64); err_cnt=0.
2. After lock, flip one bit -> err_pulse high exactly one cycle, err_cnt=1, locked stays 1, bit_cnt keeps incrementing.
3. After lock, flip 8 bits within 1024 bits -> lock_lost pulse, state=LOAD; relock after 95 further clean bits; err_cnt=8.
4. Flip 7 bits in window 1 and 7 in window 2 -> lock held, err_cnt=14.
5. All-zero input stream -> state stays LOAD indefinitely, locked=0. Also: a mismatch at VERIFY match=30 -> state returns to LOAD.
6. en=0 while locked with err_cnt=3 -> state=IDLE, locked=0, err_cnt=3 holds. Then clr=1 -> err_cnt=0. Assert rst_n mid-VERIFY -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs31_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_lock_ctrl_if
//  Description : Control/status bundle between the PRBS31 lock sequencer and
//                its sampling front end / status consumer.
//                Optional macro PRBS_INV_POL_EN adds the inv_pol input.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prbs31_lock_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             rx_valid;
    logic             rx_bit;
    logic             clr;
`ifdef PRBS_INV_POL_EN
    logic             inv_pol;
`endif
    logic [1:0]       state;
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
`ifdef PRBS_INV_POL_EN
        output inv_pol,
`endif
        output en, rx_valid, rx_bit, clr,
        input  state, locked, err_pulse, lock_lost, err_cnt, bit_cnt
    );

    modport slave (
`ifdef PRBS_INV_POL_EN
        input  inv_pol,
`endif
        input  en, rx_valid, rx_bit, clr,
        output state, locked, err_pulse, lock_lost, err_cnt, bit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/prbs31_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs31_lock_ctrl
//  Description : Self-seeding PRBS31 (x^31+x^28+1) receive checker: loads,
//                verifies, locks, counts errors, drops lock on a windowed
//                error threshold. Optional macro PRBS_INV_POL_EN enables
//                receive polarity inversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs31_lock_ctrl #(
    parameter int LOCK_CNT   = 64,
    parameter int ERR_THRESH = 8,
    parameter int WIN_LEN    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prbs31_lock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int               c_WIN_W      = $clog2(WIN_LEN + 1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST   = c_WIN_W'(WIN_LEN - 1);
    localparam logic [c_WIN_W-1:0] c_ERR_THRESH = c_WIN_W'(ERR_THRESH);
    localparam logic [15:0]      c_MATCH_LAST = 16'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    state_t             r_state;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_lock_lost;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [30:0]        r_lfsr;
    logic [4:0]         r_fill;
    logic [15:0]        r_match;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [c_WIN_W-1:0] r_win_err;

    logic               w_bit;
    logic               w_pred;
    logic               w_mismatch;
    logic [30:0]        w_lfsr_load;
    logic [30:0]        w_lfsr_pred;
    logic [c_WIN_W-1:0] w_win_err_nxt;

`ifdef PRBS_INV_POL_EN
    assign w_bit = bus.rx_bit ^ bus.inv_pol;
`else
    assign w_bit = bus.rx_bit;
`endif

    assign w_pred        = r_lfsr[30] ^ r_lfsr[27];
    assign w_mismatch    = w_bit ^ w_pred;
    assign w_lfsr_load   = {r_lfsr[29:0], w_bit};
    assign w_lfsr_pred   = {r_lfsr[29:0], w_pred};
    assign w_win_err_nxt = r_win_err + c_WIN_W'(w_mismatch);

    assign bus.state     = r_state;
    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.lock_lost = r_lock_lost;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.bit_cnt   = r_bit_cnt;

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_lfsr      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
            if (!bus.en) begin
                r_state   <= ST_IDLE;
                r_locked  <= 1'b0;
                r_fill    <= '0;
                r_match   <= '0;
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_LOAD;
                        r_fill  <= '0;
                    end
                    ST_LOAD: begin
                        if (bus.rx_valid) begin
                            r_lfsr <= w_lfsr_load;
                            if (r_fill == 5'd30) begin
                                // An all-zero seed would lock onto a dead stream
                                r_fill <= '0;
                                if (w_lfsr_load != '0) begin
                                    r_state <= ST_VERIFY;
                                    r_match <= '0;
                                end
                            end else begin
                                r_fill <= r_fill + 5'd1;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (bus.rx_valid) begin
                            if (w_mismatch) begin
                                r_state <= ST_LOAD;
                                r_fill  <= '0;
                            end else begin
                                r_lfsr <= w_lfsr_pred;
                                if (r_match == c_MATCH_LAST) begin
                                    r_state   <= ST_LOCKED;
                                    r_locked  <= 1'b1;
                                    r_match   <= '0;
                                    r_win_cnt <= '0;
                                    r_win_err <= '0;
                                end else begin
                                    r_match <= r_match + 16'd1;
                                end
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (bus.rx_valid) begin
                            r_lfsr <= w_lfsr_pred;
                            if (r_bit_cnt != c_CNT_MAX) begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                            if (w_mismatch) begin
                                r_err_pulse <= 1'b1;
                                if (r_err_cnt != c_CNT_MAX) begin
                                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                                end
                            end
                            // Threshold is checked before the window rollover so it wins on the last bit
                            if (w_win_err_nxt == c_ERR_THRESH) begin
                                r_state     <= ST_LOAD;
                                r_locked    <= 1'b0;
                                r_lock_lost <= 1'b1;
                                r_fill      <= '0;
                                r_win_cnt   <= '0;
                                r_win_err   <= '0;
                            end else if (r_win_cnt == c_WIN_LAST) begin
                                r_win_cnt <= '0;
                                r_win_err <= '0;
                            end else begin
                                r_win_cnt <= r_win_cnt + c_WIN_W'(1);
                                r_win_err <= w_win_err_nxt;
                            end
                        end
                    end
                endcase
            end
            if (bus.clr) begin
                r_err_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs31_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs31_lock_ctrl
//  Description : Directed self-checking bench for prbs31_lock_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs31_lock_ctrl;

    logic        clk;
    logic        rst_n;
    logic [30:0] gen;
    int          n_checks;
    int          n_pass;

    prbs31_lock_ctrl_if #(.CNT_W(16)) bus ();

    prbs31_lock_ctrl #(
        .LOCK_CNT   (64),
        .ERR_THRESH (8),
        .WIN_LEN    (1024),
        .CNT_W      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next bit of a reference PRBS31 stream, optionally flipped
    task automatic send(input logic flip);
        logic b;
        b   = gen[30] ^ gen[27];
        gen = {gen[29:0], b};
        bus.rx_valid = 1'b1;
        bus.rx_bit   = b ^ flip;
        tick();
    endtask

    task automatic do_reset();
        rst_n        = 1'b1;
        bus.en       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_bit   = 1'b0;
        bus.clr      = 1'b0;
`ifdef PRBS_INV_POL_EN
        bus.inv_pol  = 1'b0;
`endif
        gen = '1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic start_lock();
        bus.en       = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.state !== 2'd1) $display("FAIL start_load: state=%0d expected 1", bus.state);
        else n_pass++;
        for (int i = 0; i < 94; i++) send(1'b0);
        n_checks++;
        if (bus.locked !== 1'b0) $display("FAIL lock_early: locked=%0b expected 0 after 94 bits", bus.locked);
        else n_pass++;
        send(1'b0);
        n_checks++;
        if (bus.locked !== 1'b1 || bus.state !== 2'd3)
            $display("FAIL lock_95: locked=%0b state=%0d expected 1/3", bus.locked, bus.state);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.state, bus.locked, bus.err_pulse, bus.lock_lost} !== 5'b0 ||
            bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0)
            $display("FAIL reset_outputs: state=%0d locked=%0b ep=%0b ll=%0b err=%0d bits=%0d expected all 0",
                     bus.state, bus.locked, bus.err_pulse, bus.lock_lost, bus.err_cnt, bus.bit_cnt);
        else n_pass++;
        rst_n = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        start_lock();
        n_checks++;
        if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0)
            $display("FAIL lock_counts: err=%0d bits=%0d expected 0/0", bus.err_cnt, bus.bit_cnt);
        else n_pass++;
        for (int i = 0; i < 10; i++) send(1'b0);
        n_checks++;
        if (bus.bit_cnt !== 16'd10) $display("FAIL bit_cnt_10: bit_cnt=%0d expected 10", bus.bit_cnt);
        else n_pass++;
    endtask

    task automatic test_single_error();
        send(1'b1);
        n_checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_cnt !== 16'd1 || bus.locked !== 1'b1)
            $display("FAIL single_err: pulse=%0b err=%0d locked=%0b expected 1/1/1",
                     bus.err_pulse, bus.err_cnt, bus.locked);
        else n_pass++;
        send(1'b0);
        n_checks++;
        if (bus.err_pulse !== 1'b0 || bus.bit_cnt !== 16'd12 || bus.err_cnt !== 16'd1)
            $display("FAIL single_err_after: pulse=%0b bits=%0d err=%0d expected 0/12/1",
                     bus.err_pulse, bus.bit_cnt, bus.err_cnt);
        else n_pass++;
    endtask

    task automatic test_threshold();
        do_reset();
        start_lock();
        for (int e = 1; e <= 8; e++) begin
            for (int i = 0; i < 5; i++) send(1'b0);
            if (e == 8) begin
                n_checks++;
                if (bus.locked !== 1'b1) $display("FAIL thresh_pre: locked=%0b expected 1 after 7 errors", bus.locked);
                else n_pass++;
            end
            send(1'b1);
        end
        n_checks++;
        if (bus.lock_lost !== 1'b1 || bus.state !== 2'd1 || bus.locked !== 1'b0 || bus.err_cnt !== 16'd8)
            $display("FAIL thresh_lost: ll=%0b state=%0d locked=%0b err=%0d expected 1/1/0/8",
                     bus.lock_lost, bus.state, bus.locked, bus.err_cnt);
        else n_pass++;
        send(1'b0);
        n_checks++;
        if (bus.lock_lost !== 1'b0) $display("FAIL thresh_pulse_width: ll=%0b expected 0", bus.lock_lost);
        else n_pass++;
        for (int i = 0; i < 93; i++) send(1'b0);
        n_checks++;
        if (bus.locked !== 1'b0) $display("FAIL relock_early: locked=%0b expected 0 after 94 bits", bus.locked);
        else n_pass++;
        send(1'b0);
        n_checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd8)
            $display("FAIL relock_95: locked=%0b err=%0d expected 1/8", bus.locked, bus.err_cnt);
        else n_pass++;
    endtask

    task automatic test_thresh_last_bit();
        do_reset();
        start_lock();
        for (int i = 1; i <= 1023; i++) send(i <= 7);
        n_checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd7)
            $display("FAIL last_bit_pre: locked=%0b err=%0d expected 1/7", bus.locked, bus.err_cnt);
        else n_pass++;
        send(1'b1);
        n_checks++;
        if (bus.lock_lost !== 1'b1 || bus.state !== 2'd1)
            $display("FAIL last_bit_thresh: ll=%0b state=%0d expected 1/1", bus.lock_lost, bus.state);
        else n_pass++;
    endtask

    task automatic test_two_windows();
        logic f;
        do_reset();
        start_lock();
        for (int i = 1; i <= 2048; i++) begin
            if (i <= 1024) f = (i % 128 == 0) && (i <= 896);
            else           f = ((i - 1024) % 128 == 1) && (i - 1024 <= 769);
            send(f);
        end
        n_checks++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd14 || bus.bit_cnt !== 16'd2048)
            $display("FAIL two_windows: locked=%0b err=%0d bits=%0d expected 1/14/2048",
                     bus.locked, bus.err_cnt, bus.bit_cnt);
        else n_pass++;
    endtask

    task automatic test_load_verify();
        do_reset();
        bus.en       = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        for (int i = 0; i < 200; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_bit   = 1'b0;
            tick();
        end
        n_checks++;
        if (bus.state !== 2'd1 || bus.locked !== 1'b0)
            $display("FAIL all_zero: state=%0d locked=%0b expected 1/0", bus.state, bus.locked);
        else n_pass++;
        do_reset();
        bus.en       = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        for (int i = 0; i < 61; i++) send(1'b0);
        n_checks++;
        if (bus.state !== 2'd2) $display("FAIL verify_30: state=%0d expected 2", bus.state);
        else n_pass++;
        send(1'b1);
        n_checks++;
        if (bus.state !== 2'd1) $display("FAIL verify_mismatch: state=%0d expected 1", bus.state);
        else n_pass++;
    endtask

    task automatic test_en_clr_rst();
        do_reset();
        start_lock();
        for (int e = 0; e < 3; e++) begin
            send(1'b0);
            send(1'b1);
        end
        bus.en = 1'b0;
        send(1'b0);
        n_checks++;
        if (bus.state !== 2'd0 || bus.locked !== 1'b0 || bus.err_cnt !== 16'd3)
            $display("FAIL en_off: state=%0d locked=%0b err=%0d expected 0/0/3", bus.state, bus.locked, bus.err_cnt);
        else n_pass++;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n_checks++;
        if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0)
            $display("FAIL clr: err=%0d bits=%0d expected 0/0", bus.err_cnt, bus.bit_cnt);
        else n_pass++;
        start_lock();
        bus.clr = 1'b1;
        send(1'b1);
        bus.clr = 1'b0;
        n_checks++;
        if (bus.err_cnt !== 16'd0 || bus.err_pulse !== 1'b1)
            $display("FAIL clr_wins: err=%0d pulse=%0b expected 0/1", bus.err_cnt, bus.err_pulse);
        else n_pass++;
        bus.en = 1'b0;
        tick();
        bus.en       = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) send(1'b0);
        n_checks++;
        if (bus.state !== 2'd2) $display("FAIL pre_rst_verify: state=%0d expected 2", bus.state);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.state, bus.locked, bus.err_pulse, bus.lock_lost} !== 5'b0 ||
            bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0)
            $display("FAIL async_rst: state=%0d locked=%0b ep=%0b ll=%0b err=%0d bits=%0d expected all 0",
                     bus.state, bus.locked, bus.err_pulse, bus.lock_lost, bus.err_cnt, bus.bit_cnt);
        else n_pass++;
        rst_n = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_lock();
        test_single_error();
        test_threshold();
        test_thresh_last_bit();
        test_two_windows();
        test_load_verify();
        test_en_clr_rst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
